decode_branch_pipe: RTL and testbench

// - Parametrised decode stage with a built-in decode/execute pipeline register and valid/stall/flush handshake.
// - Resolves j, bne, jal, jr and bex in decode and issues a registered one-cycle redirect to fetch.
// - Squashes the wrong-path instruction that follows a redirect.
// - Optional 2-bit branch history table predicts blt; execute resolves blt and returns the outcome to train the table.

---
 rtl/decode_branch_pipe.sv | 197 +++++++++++++++++++
 tb/tb_decode_branch_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_branch_pipe.sv
// decode_branch_pipe: decode stage with decode/execute pipeline register.
// Resolves j, bne, jal, jr and bex in decode and issues a registered one-cycle
// redirect to fetch; the instruction following a taken branch is squashed.
// Optional feature macro: BRANCH_PREDICT_EN adds a 2-bit branch history table
// that predicts blt and is trained by execute.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_RUN    | normal decode; instructions accepted when valid and not stalled
// S_SQUASH | a taken branch was just accepted; next non-stalled slot dropped
module decode_branch_pipe #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int STATUS_REG  = 30,
  parameter int BHT_ENTRIES = 16,
  parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [31:0]       i_instr,
  input  logic [DATA_W-1:0] i_pc_plus1,
  input  logic [DATA_W-1:0] i_a_val,
  input  logic [DATA_W-1:0] i_b_val,
  output logic [REG_W-1:0]  o_reg_a,
  output logic [REG_W-1:0]  o_reg_b,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_ex_upd_valid,
  input  logic [IDX_W-1:0]  i_ex_upd_idx,
  input  logic              i_ex_upd_taken,
  output logic              o_out_valid,
  output logic [31:0]       o_out_instr,
  output logic [DATA_W-1:0] o_out_pc,
  output logic [DATA_W-1:0] o_out_a,
  output logic [DATA_W-1:0] o_out_b,
  output logic              o_out_multdiv,
  output logic              o_out_pred_taken,
  output logic              o_redirect,
  output logic [DATA_W-1:0] o_redirect_pc
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  typedef enum logic {S_RUN, S_SQUASH} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [4:0]        w_opcode;
  logic [4:0]        w_alu_op;
  logic              w_is_blt;
  logic              w_pred;
  logic              w_blt_pred;
  logic              w_taken;
  logic              w_accept;
  logic              w_multdiv;
  logic [DATA_W-1:0] w_jump_tgt;
  logic [DATA_W-1:0] w_br_tgt;
  logic [DATA_W-1:0] w_target;

  assign w_opcode   = i_instr[31:27];
  assign w_alu_op   = i_instr[6:2];
  assign w_is_blt   = (w_opcode == OP_BLT);
  assign w_blt_pred = w_is_blt & w_pred;
  assign w_multdiv  = (w_opcode == OP_RTYPE) &&
                      ((w_alu_op == 5'b00110) || (w_alu_op == 5'b00111));
  assign w_jump_tgt = {{(DATA_W-27){1'b0}}, i_instr[26:0]};
  assign w_br_tgt   = i_pc_plus1 + {{(DATA_W-17){i_instr[16]}}, i_instr[16:0]};
  assign w_accept   = i_in_valid & ~i_stall & (r_state == S_RUN) & ~i_flush;
  assign o_in_ready = ~i_stall;
  assign o_reg_a    = REG_W'(i_instr[21:17]);

  // register read address select: rt for R-type, status register for bex, rd otherwise
  always_comb begin
    o_reg_b = REG_W'(i_instr[26:22]);
    if (w_opcode == OP_RTYPE)
      o_reg_b = REG_W'(i_instr[16:12]);
    else if (w_opcode == OP_BEX)
      o_reg_b = REG_W'(STATUS_REG);
  end

  // branch resolution: taken condition and target per opcode
  always_comb begin
    w_taken  = 1'b0;
    w_target = '0;
    unique case (w_opcode)
      OP_J, OP_JAL: begin
        w_taken  = 1'b1;
        w_target = w_jump_tgt;
      end
      OP_BEX: begin
        w_taken  = (i_b_val != '0);
        w_target = w_jump_tgt;
      end
      OP_JR: begin
        w_taken  = 1'b1;
        w_target = i_b_val;
      end
      OP_BNE: begin
        w_taken  = (i_a_val != i_b_val);
        w_target = w_br_tgt;
      end
      OP_BLT: begin
        w_taken  = w_blt_pred;
        w_target = w_br_tgt;
      end
      default: ;
    endcase
  end

`ifdef BRANCH_PREDICT_EN
  logic [1:0] r_bht [BHT_ENTRIES];

  // saturating counter training from execute; lookup sees pre-update value
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < BHT_ENTRIES; k++) r_bht[k] <= 2'b01;
    end else if (i_ex_upd_valid) begin
      if (i_ex_upd_taken) begin
        if (r_bht[i_ex_upd_idx] != 2'b11) r_bht[i_ex_upd_idx] <= r_bht[i_ex_upd_idx] + 2'b01;
      end else begin
        if (r_bht[i_ex_upd_idx] != 2'b00) r_bht[i_ex_upd_idx] <= r_bht[i_ex_upd_idx] - 2'b01;
      end
    end
  end

  assign w_pred = r_bht[i_pc_plus1[IDX_W-1:0]][1];
`else
  logic w_unused_upd;
  assign w_unused_upd = ^{i_ex_upd_valid, i_ex_upd_idx, i_ex_upd_taken};
  assign w_pred       = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_RUN;
    else         r_state <= w_state_nxt;
  end

  // FSM next state: squash one non-stalled slot after a taken branch
  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = S_RUN;
    end else begin
      unique case (r_state)
        S_RUN:    if (w_accept && w_taken) w_state_nxt = S_SQUASH;
        S_SQUASH: if (!i_stall) w_state_nxt = S_RUN;
        default:  w_state_nxt = S_RUN;
      endcase
    end
  end

  // decode/execute pipeline register: reset > flush > stall > load
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_out_valid      <= 1'b0;
      o_out_instr      <= '0;
      o_out_pc         <= '0;
      o_out_a          <= '0;
      o_out_b          <= '0;
      o_out_multdiv    <= 1'b0;
      o_out_pred_taken <= 1'b0;
    end else if (i_flush) begin
      o_out_valid <= 1'b0;
    end else if (!i_stall) begin
      o_out_valid <= w_accept;
      if (w_accept) begin
        o_out_instr      <= i_instr;
        o_out_pc         <= i_pc_plus1;
        o_out_a          <= i_a_val;
        o_out_b          <= i_b_val;
        o_out_multdiv    <= w_multdiv;
        o_out_pred_taken <= w_blt_pred;
      end
    end
  end

  // one-cycle redirect pulse; target held between redirects
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_redirect    <= 1'b0;
      o_redirect_pc <= '0;
    end else begin
      o_redirect <= w_accept & w_taken;
      if (w_accept && w_taken) o_redirect_pc <= w_target;
    end
  end

endmodule

// File: tb/tb_decode_branch_pipe.sv
// Directed bench for decode_branch_pipe with hand-computed expectations.
module tb_decode_branch_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc_plus1;
  logic [31:0] a_val;
  logic [31:0] b_val;
  logic [4:0]  reg_a;
  logic [4:0]  reg_b;
  logic        stall;
  logic        flush;
  logic        upd_valid;
  logic [3:0]  upd_idx;
  logic        upd_taken;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_multdiv;
  logic        out_pred;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  decode_branch_pipe dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_in_valid       (in_valid),
    .o_in_ready       (in_ready),
    .i_instr          (instr),
    .i_pc_plus1       (pc_plus1),
    .i_a_val          (a_val),
    .i_b_val          (b_val),
    .o_reg_a          (reg_a),
    .o_reg_b          (reg_b),
    .i_stall          (stall),
    .i_flush          (flush),
    .i_ex_upd_valid   (upd_valid),
    .i_ex_upd_idx     (upd_idx),
    .i_ex_upd_taken   (upd_taken),
    .o_out_valid      (out_valid),
    .o_out_instr      (out_instr),
    .o_out_pc         (out_pc),
    .o_out_a          (out_a),
    .o_out_b          (out_b),
    .o_out_multdiv    (out_multdiv),
    .o_out_pred_taken (out_pred),
    .o_redirect       (redirect),
    .o_redirect_pc    (redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] alu);
    return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] op, input logic [26:0] tgt);
    return {op, tgt};
  endfunction

  task automatic present(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    instr    = ins;
    pc_plus1 = pc;
    a_val    = a;
    b_val    = b;
  endtask

  logic [31:0] add_i;
  logic [31:0] held_i;

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; pc_plus1 = '0; a_val = '0; b_val = '0;
    stall = 1'b0; flush = 1'b0; upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0;
    add_i = enc_r(5'd3, 5'd4, 5'd5, 5'b00000);

    tick(); tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_redirect", {31'b0, redirect}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);

    // first instruction after reset
    rst = 1'b0;
    present(add_i, 32'd10, 32'd1, 32'd2);
    #1;
    chk("rtype_reg_a", {27'b0, reg_a}, 32'd4);
    chk("rtype_reg_b", {27'b0, reg_b}, 32'd5);
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    tick();
    chk("first_valid", {31'b0, out_valid}, 32'd1);
    chk("first_instr", out_instr, add_i);
    chk("first_pc", out_pc, 32'd10);
    chk("first_a", out_a, 32'd1);
    chk("first_b", out_b, 32'd2);
    chk("first_noredir", {31'b0, redirect}, 32'd0);

    // bne taken: 100 + (-4) = 96; following instruction dropped
    present(enc_i(5'b00010, 5'd1, 5'd2, 17'h1FFFC), 32'd100, 32'd5, 32'd7);
    #1;
    chk("bne_reg_a", {27'b0, reg_a}, 32'd2);
    chk("bne_reg_b", {27'b0, reg_b}, 32'd1);
    tick();
    chk("bne_redirect", {31'b0, redirect}, 32'd1);
    chk("bne_target", redirect_pc, 32'd96);
    chk("bne_valid", {31'b0, out_valid}, 32'd1);
    present(add_i, 32'd101, 32'd0, 32'd0);
    tick();
    chk("squash_valid", {31'b0, out_valid}, 32'd0);
    chk("squash_redirect", {31'b0, redirect}, 32'd0);
    chk("squash_pc_held", redirect_pc, 32'd96);
    tick();
    chk("after_squash_valid", {31'b0, out_valid}, 32'd1);
    chk("after_squash_pc", out_pc, 32'd101);

    // bne not taken, next instruction not squashed
    present(enc_i(5'b00010, 5'd1, 5'd2, 17'h1FFFC), 32'd120, 32'd5, 32'd5);
    tick();
    chk("bne_eq_redirect", {31'b0, redirect}, 32'd0);
    chk("bne_eq_pc_held", redirect_pc, 32'd96);
    present(add_i, 32'd121, 32'd0, 32'd0);
    tick();
    chk("bne_eq_next_valid", {31'b0, out_valid}, 32'd1);

    // bex
    present(enc_j(5'b10110, 27'h1234), 32'd130, 32'd0, 32'd0);
    #1;
    chk("bex_reg_b", {27'b0, reg_b}, 32'd30);
    tick();
    chk("bex0_redirect", {31'b0, redirect}, 32'd0);
    present(enc_j(5'b10110, 27'h1234), 32'd131, 32'd0, 32'd1);
    tick();
    chk("bex1_redirect", {31'b0, redirect}, 32'd1);
    chk("bex1_target", redirect_pc, 32'h1234);
    in_valid = 1'b0;
    tick();
    chk("bex1_pulse_end", {31'b0, redirect}, 32'd0);

    // jr, then stalled squash slot holds SQUASH
    present(enc_i(5'b00100, 5'd0, 5'd0, 17'h0), 32'd140, 32'd0, 32'h40);
    tick();
    chk("jr_redirect", {31'b0, redirect}, 32'd1);
    chk("jr_target", redirect_pc, 32'h40);
    present(add_i, 32'd141, 32'd0, 32'd0);
    stall = 1'b1;
    tick(); tick();
    stall = 1'b0;
    tick();
    chk("jr_squash_drop", {31'b0, out_valid}, 32'd0);
    tick();
    chk("jr_resume_valid", {31'b0, out_valid}, 32'd1);
    chk("jr_resume_pc", out_pc, 32'd141);

    // stall holds a loaded add for 3 cycles
    held_i = enc_r(5'd7, 5'd8, 5'd9, 5'b00000);
    present(held_i, 32'd200, 32'hAA, 32'hBB);
    tick();
    present(enc_j(5'b00001, 27'h77), 32'd201, 32'h11, 32'h22);
    stall = 1'b1;
    #1;
    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_instr", out_instr, held_i);
      chk("stall_a", out_a, 32'hAA);
      chk("stall_pc", out_pc, 32'd200);
      chk("stall_noredir", {31'b0, redirect}, 32'd0);
    end
    stall = 1'b0;

    // flush with a j in the same cycle
    flush = 1'b1;
    tick();
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_redirect", {31'b0, redirect}, 32'd0);
    flush = 1'b0;
    present(add_i, 32'd210, 32'd0, 32'd0);
    tick();
    chk("post_flush_run", {31'b0, out_valid}, 32'd1);

    // multdiv decode
    present(enc_r(5'd1, 5'd2, 5'd3, 5'b00110), 32'd220, 32'd0, 32'd0);
    tick();
    chk("mult_flag", {31'b0, out_multdiv}, 32'd1);
    present(enc_r(5'd1, 5'd2, 5'd3, 5'b00111), 32'd221, 32'd0, 32'd0);
    tick();
    chk("div_flag", {31'b0, out_multdiv}, 32'd1);
    present(enc_r(5'd1, 5'd2, 5'd3, 5'b00000), 32'd222, 32'd0, 32'd0);
    tick();
    chk("add_flag", {31'b0, out_multdiv}, 32'd0);

    // blt at index 3
    present(enc_i(5'b00110, 5'd1, 5'd2, 17'd5), 32'd3, 32'd0, 32'd0);
    tick();
    chk("blt_init_pred", {31'b0, out_pred}, 32'd0);
    chk("blt_init_redir", {31'b0, redirect}, 32'd0);

`ifdef BRANCH_PREDICT_EN
    in_valid  = 1'b0;
    upd_valid = 1'b1; upd_idx = 4'd3; upd_taken = 1'b1;
    tick(); tick();
    upd_valid = 1'b0;
    present(enc_i(5'b00110, 5'd1, 5'd2, 17'd5), 32'd3, 32'd0, 32'd0);
    tick();
    chk("blt_trained_pred", {31'b0, out_pred}, 32'd1);
    chk("blt_trained_redir", {31'b0, redirect}, 32'd1);
    chk("blt_trained_tgt", redirect_pc, 32'd8);
    in_valid  = 1'b0;
    upd_valid = 1'b1; upd_taken = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    upd_valid = 1'b0;
    present(enc_i(5'b00110, 5'd1, 5'd2, 17'd5), 32'd3, 32'd0, 32'd0);
    tick();
    chk("blt_sat0_pred", {31'b0, out_pred}, 32'd0);
    in_valid  = 1'b0;
    upd_valid = 1'b1; upd_taken = 1'b1;
    tick();
    upd_valid = 1'b0;
    present(enc_i(5'b00110, 5'd1, 5'd2, 17'd5), 32'd3, 32'd0, 32'd0);
    tick();
    chk("blt_one_inc_pred", {31'b0, out_pred}, 32'd0);
`else
    // training inputs have no effect without the table
    in_valid  = 1'b0;
    upd_valid = 1'b1; upd_idx = 4'd3; upd_taken = 1'b1;
    tick(); tick(); tick();
    upd_valid = 1'b0;
    present(enc_i(5'b00110, 5'd1, 5'd2, 17'd5), 32'd3, 32'd0, 32'd0);
    tick();
    chk("blt_nobht_pred", {31'b0, out_pred}, 32'd0);
    chk("blt_nobht_redir", {31'b0, redirect}, 32'd0);
`endif

    in_valid = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
